lenet_maxpool_engine: RTL
=========================

# lenet_maxpool_engine

Sequential 2×2/stride-2 max-pool engine for the LeNet-5 inference datapath. It reads a conv output feature map from working-memory Buffer A and writes the pooled map into Buffer B (Pool1) or Buffer C (Pool2). Buffer A reads are zero-latency (distributed RAM, combinational read data); writes land on the next clock edge. One instance is parameterized per pooling layer and sequenced by the layer controller with a start/done handshake.

## Interface
- `CHANNELS`, default 6: feature-map channels (6 for Pool1, 16 for Pool2).
- `IN_DIM`, default 28: input height/width; must be even (28 or 10).
- `RD_AW`, default 13: Buffer A address width.
- `WR_AW`, default 11: destination buffer address width (11 for Buffer B, 9 for Buffer C).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `busy`  out  1  high while a layer is in progress.
- `done`  out  1  one-cycle pulse after the final write.
- `rd_addr`  out  RD_AW  Buffer A address.
- `rd_data`  in  8  Buffer A data, signed int8, valid in the same cycle as `rd_addr`.
- `wr_addr`  out  WR_AW  destination address.
- `wr_data`  out  8  pooled value, signed int8.
- `wr_en`  out  1  destination write strobe.

## Operation
- OD = IN_DIM/2. Outputs are indexed o = ch·OD·OD + r·OD + c, processed in increasing o order (channel-major, then row, then column). `wr_addr` = o.
- Window base address = ch·IN_DIM² + 2r·IN_DIM + 2c. Reads are issued in the order base, base+1, base+IN_DIM, base+IN_DIM+1. Addresses are kept in incremental counters; no runtime multipliers.
- FSM states: IDLE → RD0 → RD1 → RD2 → RD3 → WR → (RD0 for the next output | FIN) → IDLE.
  - RD0: capture `rd_data` into the max register.
  - RD1..RD3: max ← signed max(max, `rd_data`).
  - WR: `wr_en`=1, `wr_data`=max, `wr_addr`=o. Advance o.
  - FIN: `done`=1.
- Comparison is signed 8-bit. On equal values the register holds its current value; the result is identical either way.
- `start` in any state other than IDLE is ignored, and no restart occurs.
- Outside WR, `wr_en`=0, and `wr_addr` and `wr_data` hold their last values. Outside RD0..RD3, `rd_addr` holds its last value.

## Timing
- Reset: the FSM enters IDLE. `busy`, `done`, `wr_en` are 0. `rd_addr`, `wr_addr`, `wr_data`, and all counters and the max register are 0. Reset asserted mid-layer aborts immediately, with no further writes; a new `start` is required after release.
- If `start` is high at edge N in IDLE, the FSM is in RD0 from edge N and `busy`=1 from edge N.
- Each output takes 5 cycles (RD0–RD3, WR). The write commits at the clock edge that ends the WR cycle.
- FIN follows the last WR. `done`=1 for exactly one cycle, and `busy` is still 1 during FIN. `busy` drops to 0 when the FSM returns to IDLE.
- Total cycles from the first RD0 to `done` inclusive = 5·CHANNELS·OD² + 1. This is 5881 for Pool1 and 2001 for Pool2.
- `start` is accepted in the cycle immediately after `busy` falls, so back-to-back layers are possible.

## Configuration
- `POOL_RELU_EN` defined: the WR value is max(max, 0), which fuses a ReLU into the pooling step. Negative window maxima write 0x00.
- `POOL_RELU_EN` undefined: raw signed max is written, and negative results pass through unchanged. The FSM and timing are identical in both builds.

## Test plan
- CHANNELS=1, IN_DIM=2, window {3,−5,7,1} → single write addr 0 data 7. `done` 6 cycles after the first RD0, and `busy` low the following cycle.
- Pool1 default, Buffer A[i] = i mod 128 → 1176 writes in addresses 0..1175 ascending. Output (ch0, r0, c0) = 29, `done` at cycle 5881.
- Window all −128 / {−128,127,−1,0} → writes 0x80 (RELU off) or 0x00 (RELU on), and 127 respectively.
- `start` pulsed again at cycle 100 of a Pool2 run → ignored. Exactly 400 writes, one `done`.
- `rst_n` low at cycle 50 → `wr_en`, `busy`, and `done` are 0 immediately, with no writes after reset. A fresh `start` produces the full correct 400-write sequence.
- Pool2 (16, 10, WR_AW=9) with the golden model comparing every write → all 400 match, and the read address sequence never exceeds 1599.

Source files
------------

// File: rtl/lenet_maxpool_engine_if.sv
// Bus bundle for lenet_maxpool_engine: layer handshake, Buffer A read port,
// destination buffer write port and an FSM state tap for checkers.
//
// Handshake: the controller raises start for one cycle while busy is low.
// The engine accepts it on that edge, holds busy high until it returns to
// IDLE and pulses done for exactly one cycle (FIN) with busy still high.
// start while busy is high is ignored. rd_data must be valid in the same
// cycle as rd_addr. A write happens on each clock edge where wr_en is high.
interface lenet_maxpool_engine_if #(
  parameter int RD_AW = 13,
  parameter int WR_AW = 11
);
  logic             start;
  logic             busy;
  logic             done;
  logic [RD_AW-1:0] rd_addr;
  logic [7:0]       rd_data;
  logic [WR_AW-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             wr_en;
  logic [2:0]       dbg_state;

  modport master (
    output start,
    output rd_data,
    input  busy,
    input  done,
    input  rd_addr,
    input  wr_addr,
    input  wr_data,
    input  wr_en,
    input  dbg_state
  );

  modport slave (
    input  start,
    input  rd_data,
    output busy,
    output done,
    output rd_addr,
    output wr_addr,
    output wr_data,
    output wr_en,
    output dbg_state
  );
endinterface

// File: rtl/lenet_maxpool_engine.sv
// lenet_maxpool_engine: sequential 2x2 / stride-2 signed int8 max-pool.
// Reads a CHANNELS x IN_DIM x IN_DIM map from Buffer A (combinational read)
// and writes CHANNELS x OD x OD pooled values (OD = IN_DIM/2) to the
// destination buffer, one output every 5 cycles (RD0..RD3, WR).
// Optional build macro POOL_RELU_EN: clamp negative window maxima to 0
// before writing (fused ReLU). FSM and timing are the same either way.
module lenet_maxpool_engine #(
  parameter int CHANNELS = 6,
  parameter int IN_DIM   = 28,
  parameter int RD_AW    = 13,
  parameter int WR_AW    = 11
) (
  input logic                   clk,
  input logic                   rst_n,
  lenet_maxpool_engine_if.slave bus
);

  localparam int OD    = IN_DIM / 2;
  localparam int N_OUT = CHANNELS * OD * OD;
  localparam int CW    = (OD > 1) ? $clog2(OD) : 1;

  // Window read offsets and base-address steps, resolved at elaboration.
  localparam logic [RD_AW-1:0] L_OFS_1     = RD_AW'(1);
  localparam logic [RD_AW-1:0] L_OFS_DIM   = RD_AW'(IN_DIM);
  localparam logic [RD_AW-1:0] L_OFS_DIM1  = RD_AW'(IN_DIM + 1);
  localparam logic [RD_AW-1:0] L_STEP_COL  = RD_AW'(2);
  // At the end of a row the base skips the odd input row; the same step
  // also lands exactly on the next channel after the last row.
  localparam logic [RD_AW-1:0] L_STEP_ROW  = RD_AW'(IN_DIM + 2);
  localparam logic [WR_AW-1:0] L_LAST_O    = WR_AW'(N_OUT - 1);
  localparam logic [CW-1:0]    L_LAST_COL  = CW'(OD - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_RD2  = 3'd3;
  localparam logic [2:0] S_RD3  = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [RD_AW-1:0]  r_base;
  logic [RD_AW-1:0]  r_rd_addr;
  logic [RD_AW-1:0]  w_next_base;
  logic signed [7:0] r_max;
  logic signed [7:0] w_rd_s;
  logic signed [7:0] w_max_next;
  logic signed [7:0] w_wr_val;
  logic [WR_AW-1:0]  r_o;
  logic [CW-1:0]     r_col;
  logic [WR_AW-1:0]  r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              w_last;
  logic              w_col_end;

  assign w_rd_s     = bus.rd_data;
  // Strict greater-than: on ties the register keeps its current value.
  assign w_max_next = (w_rd_s > r_max) ? w_rd_s : r_max;
  assign w_last     = (r_o == L_LAST_O);
  assign w_col_end  = (r_col == L_LAST_COL);
  assign w_next_base = w_col_end ? (r_base + L_STEP_ROW) : (r_base + L_STEP_COL);

`ifdef POOL_RELU_EN
  assign w_wr_val = w_max_next[7] ? 8'sd0 : w_max_next;
`else
  assign w_wr_val = w_max_next;
`endif

  // Next-state logic: five-cycle loop per output, FIN after the last write.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_RD0;
      S_RD0:   w_state_next = S_RD1;
      S_RD1:   w_state_next = S_RD2;
      S_RD2:   w_state_next = S_RD3;
      S_RD3:   w_state_next = S_WR;
      S_WR:    w_state_next = w_last ? S_FIN : S_RD0;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any layer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Read address walk: base, +1, +IN_DIM, +IN_DIM+1, then next window base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base    <= '0;
      r_rd_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base    <= '0;
            r_rd_addr <= '0;
          end
        end
        S_RD0: r_rd_addr <= r_base + L_OFS_1;
        S_RD1: r_rd_addr <= r_base + L_OFS_DIM;
        S_RD2: r_rd_addr <= r_base + L_OFS_DIM1;
        S_WR: begin
          if (!w_last) begin
            r_base    <= w_next_base;
            r_rd_addr <= w_next_base;
          end
        end
        default: ;
      endcase
    end
  end

  // Running window maximum; the final value is staged for the WR cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max     <= '0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
    end else begin
      case (r_state)
        S_RD0: r_max <= w_rd_s;
        S_RD1: r_max <= w_max_next;
        S_RD2: r_max <= w_max_next;
        S_RD3: begin
          r_max     <= w_max_next;
          r_wr_data <= w_wr_val;
          r_wr_addr <= r_o;
        end
        default: ;
      endcase
    end
  end

  // Output index and column counters advance once per written output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o   <= '0;
      r_col <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_o   <= '0;
      r_col <= '0;
    end else if (r_state == S_WR) begin
      r_o   <= r_o + WR_AW'(1);
      r_col <= w_col_end ? '0 : (r_col + CW'(1));
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FIN);
  assign bus.wr_en     = (r_state == S_WR);
  assign bus.rd_addr   = r_rd_addr;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.dbg_state = r_state;

endmodule
